ram_port_arbiter: RTL and testbench

//  Shares the single-port RAM between instruction fetch (IF) and load/store data (D) requesters.

---
 rtl/ram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between instruction fetch and load/store data.
// Default policy: data priority with a fetch starvation guard; define RAM_ARB_RR_EN for round-robin.
module ram_port_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_w_en,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ACC_IF  = 3'd1,
      ACC_DR  = 3'd2,
      ACC_DW  = 3'd3,
      RESP_IF = 3'd4,
      RESP_D  = 3'd5
   } state_e;

   localparam int   WCNT_W = $clog2(MAX_WAIT + 1);
   localparam logic WIN_D  = 1'b0;
   localparam logic WIN_IF = 1'b1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              last_win_q, last_win_d;
   logic              both_s;
   logic              if_wins_s;

   // Arbitration decision for the current IDLE sample
   always_comb begin
      both_s = if_req & d_req;
`ifdef RAM_ARB_RR_EN
      if (both_s) begin
         if_wins_s = (last_win_q == WIN_D);
      end else begin
         if_wins_s = if_req;
      end
`else
      if (both_s) begin
         if_wins_s = (wait_cnt_q == WCNT_W'(MAX_WAIT));
      end else begin
         if_wins_s = if_req;
      end
`endif
   end

   // Next-state, latched access and starvation counter
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wait_cnt_d = wait_cnt_q;
      last_win_d = last_win_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (if_req | d_req) begin
               if (if_wins_s) begin
                  state_d    = ACC_IF;
                  addr_d     = if_addr;
                  last_win_d = WIN_IF;
                  wait_cnt_d = {WCNT_W{1'b0}};
               end else begin
                  state_d    = d_we ? ACC_DW : ACC_DR;
                  addr_d     = d_addr;
                  wdata_d    = d_wdata;
                  last_win_d = WIN_D;
                  if (if_req && (wait_cnt_q != WCNT_W'(MAX_WAIT))) begin
                     wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                  end else begin
                     wait_cnt_d = wait_cnt_q;
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACC_IF:  state_d = RESP_IF;
         ACC_DR:  state_d = RESP_D;
         ACC_DW:  state_d = IDLE;
         RESP_IF: begin
            state_d    = IDLE;
            if_rdata_d = ram_rdata;
         end
         RESP_D: begin
            state_d   = IDLE;
            d_rdata_d = ram_rdata;
         end
         default: state_d = IDLE;
      endcase
`ifdef RAM_ARB_RR_EN
      wait_cnt_d = {WCNT_W{1'b0}};
`endif
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= {ADDR_W{1'b0}};
         wdata_q    <= {DATA_W{1'b0}};
         if_rdata_q <= {DATA_W{1'b0}};
         d_rdata_q  <= {DATA_W{1'b0}};
         wait_cnt_q <= {WCNT_W{1'b0}};
         last_win_q <= WIN_D;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         wait_cnt_q <= wait_cnt_d;
         last_win_q <= last_win_d;
      end
   end

   // Outputs decode straight from the state register, so async reset drops them at once
   always_comb begin
      if_gnt    = (state_q == ACC_IF);
      d_gnt     = (state_q == ACC_DR) || (state_q == ACC_DW);
      ram_w_en  = (state_q == ACC_DW);
      ram_wdata = (state_q == ACC_DW) ? wdata_q : {DATA_W{1'b0}};
      ram_addr  = addr_q;
      if_rvalid = (state_q == RESP_IF);
      d_rvalid  = (state_q == RESP_D);
      if_rdata  = (state_q == RESP_IF) ? ram_rdata : if_rdata_q;
      d_rdata   = (state_q == RESP_D) ? ram_rdata : d_rdata_q;
      busy      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a transaction-level timing model.
module tb_ram_port_arbiter;
   localparam int AW   = 8;
   localparam int DW   = 16;
   localparam int MAXW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata;
   logic          if_gnt, if_rvalid, d_gnt, d_rvalid, ram_w_en, busy;
   logic [DW-1:0] if_rdata, d_rdata, ram_wdata, ram_rdata;
   logic [AW-1:0] ram_addr;

   ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_w_en(ram_w_en), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM seen by the DUT
   logic [DW-1:0] ram_mem [0:255];
   always @(posedge clk) begin
      if (ram_w_en) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   // Reference state: memory contents, arbitration history, scheduled access
   logic [DW-1:0] m_mem [0:255];
   int            edge_n = 0, free_edge = 0, acc_edge = -100;
   bit            cur_if, cur_we, pend_wr;
   logic [AW-1:0] cur_addr;
   logic [DW-1:0] cur_wdata, cur_rd, exp_if_rdata, exp_d_rdata;
   int            m_wait;
   bit            m_last_if;
   bit            e_if_gnt, e_d_gnt, e_wen, e_if_rv, e_d_rv, in_acc, in_resp;
   bit            dut_gnt_log [$];
   int            mode;
   int            checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      free_edge    = edge_n;
      acc_edge     = -100;
      pend_wr      = 1'b0;
      m_wait       = 0;
      m_last_if    = 1'b0;
      exp_if_rdata = '0;
      exp_d_rdata  = '0;
   endtask

   task automatic model_edge();
      bit both;
      edge_n++;
      if (pend_wr) begin
         m_mem[cur_addr] = cur_wdata;
         pend_wr = 1'b0;
      end
      if (edge_n >= free_edge && (if_req || d_req)) begin
         both = if_req && d_req;
`ifdef RAM_ARB_RR_EN
         cur_if = both ? !m_last_if : if_req;
`else
         cur_if = both ? (m_wait >= MAXW) : if_req;
         if (cur_if) m_wait = 0;
         else if (if_req) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
`endif
         m_last_if = cur_if;
         cur_we    = !cur_if && d_we;
         cur_addr  = cur_if ? if_addr : d_addr;
         cur_wdata = d_wdata;
         cur_rd    = m_mem[cur_addr];
         pend_wr   = cur_we;
         acc_edge  = edge_n;
         free_edge = edge_n + (cur_we ? 2 : 3);
      end
   endtask

   task automatic check_cycle();
      in_acc   = (acc_edge == edge_n);
      in_resp  = (acc_edge == edge_n - 1) && !cur_we;
      e_if_gnt = in_acc && cur_if;
      e_d_gnt  = in_acc && !cur_if;
      e_wen    = in_acc && cur_we;
      e_if_rv  = in_resp && cur_if;
      e_d_rv   = in_resp && !cur_if;
      if (e_if_rv) exp_if_rdata = cur_rd;
      if (e_d_rv)  exp_d_rdata  = cur_rd;
      if (if_gnt || d_gnt) dut_gnt_log.push_back(if_gnt);
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
      chk("ram_w_en", 32'(ram_w_en), 32'(e_wen));
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
      chk("busy", 32'(busy), 32'(in_acc || in_resp));
      chk("if_rdata", 32'(if_rdata), 32'(exp_if_rdata));
      chk("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
      if (in_acc) chk("ram_addr", 32'(ram_addr), 32'(cur_addr));
      if (e_wen)  chk("ram_wdata", 32'(ram_wdata), 32'(cur_wdata));
   endtask

   function automatic logic [AW-1:0] pick_addr();
      logic [AW-1:0] a;
      if ($urandom_range(0, 9) == 0) a = 8'hFF;
      else a = 8'($urandom_range(0, 15));
      return a;
   endfunction

   task automatic drive();
      if (e_if_gnt) if_req = 1'b0;
      if (e_d_gnt)  d_req  = 1'b0;
      if (mode == 2) begin
         if (!if_req) begin if_req = 1'b1; if_addr = pick_addr(); end
         if (!d_req)  begin d_req = 1'b1; d_we = 1'b0; d_addr = pick_addr(); end
      end else if (mode == 1) begin
         if (!if_req && $urandom_range(0, 3) == 0) begin if_req = 1'b1; if_addr = pick_addr(); end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = pick_addr(); d_wdata = DW'($urandom);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_cycle();
      drive();
   endtask

   initial begin
      logic [9:0] pat;
      logic [DW-1:0] v;
      rst_n = 1'b0; mode = 0;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int k = 0; k < 256; k++) begin
         v = DW'($urandom);
         ram_mem[k] <= v;
         m_mem[k] = v;
      end
      ram_mem[5] <= 16'hA5A5;    m_mem[5] = 16'hA5A5;
      ram_mem[32] <= 16'h0F0F;   m_mem[32] = 16'h0F0F;
      #3;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, ram_w_en}), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
      chk("rst_rdata", 32'({if_rdata, d_rdata}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // IF-only fetch of a known word
      if_req = 1'b1; if_addr = 8'h05;
      for (int i = 0; i < 4; i++) step();
      chk("t2_if_rdata", 32'(if_rdata), 32'h0000A5A5);

      // Store then load back the same word
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'h1234;
      for (int i = 0; i < 3; i++) step();
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
      for (int i = 0; i < 4; i++) step();
      chk("t3_d_rdata", 32'(d_rdata), 32'h00001234);

      // Simultaneous requests: data first, fetch at the next IDLE
      dut_gnt_log.delete();
      if_req = 1'b1; if_addr = 8'h05; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
      for (int i = 0; i < 7; i++) step();
      chk("t4_ngrants", 32'(dut_gnt_log.size()), 32'd2);
      if (dut_gnt_log.size() == 2) begin
         chk("t4_first_d", 32'(dut_gnt_log[0]), 32'd0);
         chk("t4_then_if", 32'(dut_gnt_log[1]), 32'd1);
      end

      // Both requesters held continuously for ten contended decisions
      dut_gnt_log.delete();
      mode = 2;
`ifdef RAM_ARB_RR_EN
      pat = 10'b1010101010;
`else
      pat = 10'b1000010000;
`endif
      for (int i = 0; i < 200 && dut_gnt_log.size() < 10; i++) step();
      chk("t5_ngrants", 32'(dut_gnt_log.size() >= 10), 32'd1);
      for (int i = 0; i < 10 && i < dut_gnt_log.size(); i++)
         chk($sformatf("t5_grant%0d", i), 32'(dut_gnt_log[i]), 32'(pat[i]));
      mode = 0; if_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 4; i++) step();

      // Reset while a store is on the RAM bus
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 16'hBEEF;
      for (int i = 0; i < 10 && !e_wen; i++) step();
      chk("t1_wen_seen", 32'(ram_w_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t1_wen_drop", 32'(ram_w_en), 32'd0);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_strobes", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid}), 32'd0);
      d_req = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
      for (int i = 0; i < 4; i++) step();
      chk("t1_no_write", 32'(d_rdata), 32'h00000F0F);

      // Random traffic, including the top address
      mode = 1;
      for (int i = 0; i < 600; i++) step();
      mode = 0; if_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 4; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
